// File: rtl/compress_wr_arbiter.sv
// compress_wr_arbiter
//   Shares one registered memory write port between NUM_CH compressor lanes.
//   Requesting lanes are granted round-robin starting at rr_ptr; the granted
//   lane's word is registered onto the write port at that lane's next
//   sequential address (base + words granted so far). Once every lane reports
//   ch_last, no lane is requesting and the output slot is empty, the block
//   moves to DONE and stays there until the next cfg_start.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   cfg_start       load bases, clear counters, enter RUN (ignored in RUN)
//   cfg_base_addr   per-lane base address, lane i at [i*ADDR_W +: ADDR_W]
//   ch_req/ch_data  lane write requests and words (held until acked)
//   ch_last         per-lane "no more words" level
//   ch_ack          combinational one-hot grant back to the lanes
//   wr_en/addr/data registered write port, accepted when wr_en && wr_ready
//   wr_ready        memory side accept
//   ch_word_cnt     per-lane words granted since the last cfg_start
//   busy, done      state == RUN, state == DONE
module compress_wr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [NUM_CH*ADDR_W-1:0] cfg_base_addr,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_last,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic                     wr_ready,
  output logic [NUM_CH*ADDR_W-1:0] ch_word_cnt,
  output logic                     busy,
  output logic                     done
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [PTR_W-1:0]               rr_ptr_q, rr_next;
  logic [PTR_W-1:0]               grant_idx;
  logic                           any_req;
  logic                           grant_valid;
  logic                           slot_free;
  logic                           cfg_accept;
  logic                           drain_ok;
  logic [DATA_W-1:0]              grant_data;
  logic [NUM_CH-1:0][ADDR_W-1:0]  base_q;
  logic [NUM_CH-1:0][ADDR_W-1:0]  cnt_q;

  // The output register can take a new word when empty or being drained now.
  assign slot_free   = !wr_en || wr_ready;
  assign cfg_accept  = cfg_start && (state_q != RUN);
  assign drain_ok    = (&ch_last) && !(|ch_req) && !wr_en;
  assign grant_valid = (state_q == RUN) && slot_free && any_req;
  assign grant_data  = ch_data[int'(grant_idx)*DATA_W +: DATA_W];

  assign ch_word_cnt = cnt_q;
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);

  // Rotating-priority search: lanes rr_ptr, rr_ptr+1, ... wrapping at NUM_CH.
  always_comb begin : grant_search
    logic [PTR_W:0] cand;
    logic           found;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the paths that skip it would infer a latch.
    cand      = '0;
    found     = 1'b0;
    grant_idx = rr_ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_CH)) cand = cand - (PTR_W+1)'(NUM_CH);
      if (!found && ch_req[cand[PTR_W-1:0]]) begin
        grant_idx = cand[PTR_W-1:0];
        found     = 1'b1;
      end
    end
    any_req = found;
  end

  // Pointer moves to the lane after the winner so it has lowest priority next.
  always_comb begin : rr_advance
    logic [PTR_W:0] nxt;
    nxt = {1'b0, grant_idx} + (PTR_W+1)'(1);
    if (nxt >= (PTR_W+1)'(NUM_CH)) nxt = '0;
    rr_next = nxt[PTR_W-1:0];
  end

  always_comb begin
    ch_ack = '0;
    if (grant_valid) ch_ack[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_start) state_d = RUN;
      RUN:     if (drain_ok)  state_d = DONE;
      DONE:    if (cfg_start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: the base and counter arrays are reset explicitly because their
  // values are architecturally visible (ch_word_cnt) straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      if (cfg_accept) begin
        base_q   <= cfg_base_addr;
        cnt_q    <= '0;
        rr_ptr_q <= '0;
      end
      if (grant_valid) begin
        wr_en            <= 1'b1;
        wr_data          <= grant_data;
        wr_addr          <= base_q[grant_idx] + cnt_q[grant_idx];
        cnt_q[grant_idx] <= cnt_q[grant_idx] + ADDR_W'(1);
        rr_ptr_q         <= rr_next;
      end else if (wr_ready) begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_compress_wr_arbiter.sv
// Directed bench for compress_wr_arbiter (NUM_CH=4, ADDR_W=16, DATA_W=64).
// Inputs change just after the falling edge; outputs are sampled 1 ns later,
// so ch_ack shows the current cycle's grant and the write port shows the
// result of the preceding rising edge.
module tb_compress_wr_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     cfg_start = 1'b0;
  logic [NUM_CH*ADDR_W-1:0] cfg_base_addr = '0;
  logic [NUM_CH-1:0]        ch_req = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0]        ch_last = '0;
  logic [NUM_CH-1:0]        ch_ack;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_ready = 1'b1;
  logic [NUM_CH*ADDR_W-1:0] ch_word_cnt;
  logic                     busy;
  logic                     done;

  int vec_cnt = 0;
  int err_cnt = 0;

  compress_wr_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .ch_req(ch_req), .ch_data(ch_data), .ch_last(ch_last), .ch_ack(ch_ack),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .ch_word_cnt(ch_word_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word0(int lane);
    return 64'hDA7A_0000_0000_0000 + 64'(lane);
  endfunction

  function automatic logic [ADDR_W-1:0] cnt_of(int lane);
    return ch_word_cnt[lane*ADDR_W +: ADDR_W];
  endfunction

  task automatic set_data(int lane, logic [DATA_W-1:0] v);
    ch_data[lane*DATA_W +: DATA_W] = v;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    vec_cnt++; if (wr_en !== 1'b0) begin err_cnt++; $display("FAIL rst_wr_en: got %b exp 0", wr_en); end
    vec_cnt++; if (wr_addr !== 16'h0) begin err_cnt++; $display("FAIL rst_wr_addr: got %h exp 0", wr_addr); end
    vec_cnt++; if (wr_data !== 64'h0) begin err_cnt++; $display("FAIL rst_wr_data: got %h exp 0", wr_data); end
    vec_cnt++; if (ch_ack !== 4'b0) begin err_cnt++; $display("FAIL rst_ack: got %b exp 0000", ch_ack); end
    vec_cnt++; if (ch_word_cnt !== '0) begin err_cnt++; $display("FAIL rst_cnt: got %h exp 0", ch_word_cnt); end
    vec_cnt++; if ({busy, done} !== 2'b00) begin err_cnt++; $display("FAIL rst_busy_done: got %b exp 00", {busy, done}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // All four lanes request continuously: strict rotation, one word per cycle.
  task automatic test_round_robin();
    logic [ADDR_W-1:0] ea [5] = '{16'h000, 16'h100, 16'h200, 16'h300, 16'h001};
    logic [NUM_CH-1:0] exp_ack;
    @(negedge clk);
    cfg_base_addr = {16'h300, 16'h200, 16'h100, 16'h000};
    cfg_start = 1'b1;
    for (int l = 0; l < NUM_CH; l++) set_data(l, word0(l));
    @(negedge clk);
    cfg_start = 1'b0;
    ch_req = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) ch_req = 4'h0;
      #1;
      exp_ack = (i < 5) ? (4'b0001 << (i % 4)) : 4'b0000;
      vec_cnt++; if (ch_ack !== exp_ack) begin err_cnt++; $display("FAIL rr_ack[%0d]: got %b exp %b", i, ch_ack, exp_ack); end
      if (i == 0) begin
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rr_busy: got %b exp 1", busy); end
      end
      if (i > 0) begin
        vec_cnt++; if (wr_en !== 1'b1) begin err_cnt++; $display("FAIL rr_wr_en[%0d]: got %b exp 1", i, wr_en); end
        vec_cnt++; if (wr_addr !== ea[i-1]) begin err_cnt++; $display("FAIL rr_addr[%0d]: got %h exp %h", i, wr_addr, ea[i-1]); end
        vec_cnt++; if (wr_data !== word0((i-1) % 4)) begin err_cnt++; $display("FAIL rr_data[%0d]: got %h exp %h", i, wr_data, word0((i-1) % 4)); end
      end
      @(negedge clk);
    end
    #1;
    vec_cnt++; if (wr_en !== 1'b0) begin err_cnt++; $display("FAIL rr_wr_en_end: got %b exp 0", wr_en); end
    vec_cnt++; if (cnt_of(0) !== 16'd2) begin err_cnt++; $display("FAIL rr_cnt0: got %0d exp 2", cnt_of(0)); end
    vec_cnt++; if (cnt_of(3) !== 16'd1) begin err_cnt++; $display("FAIL rr_cnt3: got %0d exp 1", cnt_of(3)); end
  endtask

  // Lane 2 alone; memory stalls 3 cycles after the first grant.
  task automatic test_stall();
    @(negedge clk);
    ch_req = 4'b0100;
    set_data(2, 64'h2222_0000_0000_0001);
    #1;
    vec_cnt++; if (ch_ack !== 4'b0100) begin err_cnt++; $display("FAIL st_ack_first: got %b exp 0100", ch_ack); end
    @(negedge clk);
    set_data(2, 64'h2222_0000_0000_0002);
    wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      vec_cnt++; if (ch_ack !== 4'b0) begin err_cnt++; $display("FAIL st_ack_stall[%0d]: got %b exp 0000", k, ch_ack); end
      vec_cnt++; if ({wr_en, wr_addr} !== {1'b1, 16'h0201}) begin err_cnt++; $display("FAIL st_hold[%0d]: got %b/%h exp 1/0201", k, wr_en, wr_addr); end
      vec_cnt++; if (wr_data !== 64'h2222_0000_0000_0001) begin err_cnt++; $display("FAIL st_data[%0d]: got %h exp 2222000000000001", k, wr_data); end
    end
    @(negedge clk);
    wr_ready = 1'b1;
    #1;
    vec_cnt++; if (ch_ack !== 4'b0100) begin err_cnt++; $display("FAIL st_ack_resume: got %b exp 0100", ch_ack); end
    vec_cnt++; if (wr_addr !== 16'h0201) begin err_cnt++; $display("FAIL st_addr_resume: got %h exp 0201", wr_addr); end
    @(negedge clk);
    ch_req = 4'b0;
    #1;
    vec_cnt++; if ({wr_en, wr_addr} !== {1'b1, 16'h0202}) begin err_cnt++; $display("FAIL st_second: got %b/%h exp 1/0202", wr_en, wr_addr); end
    vec_cnt++; if (wr_data !== 64'h2222_0000_0000_0002) begin err_cnt++; $display("FAIL st_second_data: got %h exp 2222000000000002", wr_data); end
    @(negedge clk);
    #1;
    vec_cnt++; if (wr_en !== 1'b0) begin err_cnt++; $display("FAIL st_idle: got %b exp 0", wr_en); end
    vec_cnt++; if (cnt_of(2) !== 16'd3) begin err_cnt++; $display("FAIL st_cnt2: got %0d exp 3", cnt_of(2)); end
  endtask

  // All lanes last, lane 1 has one word stuck behind wr_ready=0; cfg_start in RUN.
  task automatic test_drain_done();
    @(negedge clk);
    ch_last = 4'hF;
    ch_req = 4'b0010;
    wr_ready = 1'b0;
    set_data(1, 64'h1111_0000_0000_0009);
    #1;
    vec_cnt++; if (ch_ack !== 4'b0010) begin err_cnt++; $display("FAIL dr_ack: got %b exp 0010", ch_ack); end
    @(negedge clk);
    ch_req = 4'b0;
    cfg_start = 1'b1;
    cfg_base_addr = {4{16'hABCD}};
    #1;
    vec_cnt++; if ({wr_en, wr_addr} !== {1'b1, 16'h0101}) begin err_cnt++; $display("FAIL dr_wr: got %b/%h exp 1/0101", wr_en, wr_addr); end
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL dr_done_early0: got %b exp 0", done); end
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    vec_cnt++; if ({busy, done, wr_en} !== 3'b101) begin err_cnt++; $display("FAIL dr_stalled: got %b exp 101", {busy, done, wr_en}); end
    @(negedge clk);
    wr_ready = 1'b1;
    #1;
    vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL dr_done_early1: got %b exp 0", done); end
    @(negedge clk);
    #1;
    vec_cnt++; if ({busy, done, wr_en} !== 3'b100) begin err_cnt++; $display("FAIL dr_drained: got %b exp 100", {busy, done, wr_en}); end
    @(negedge clk);
    ch_req = 4'hF;
    #1;
    vec_cnt++; if ({busy, done} !== 2'b01) begin err_cnt++; $display("FAIL dr_done: got %b exp 01", {busy, done}); end
    vec_cnt++; if (ch_ack !== 4'b0) begin err_cnt++; $display("FAIL dr_ack_in_done: got %b exp 0000", ch_ack); end
    vec_cnt++; if (cnt_of(0) !== 16'd2 || cnt_of(1) !== 16'd2) begin err_cnt++; $display("FAIL dr_cfg_ignored: got %0d/%0d exp 2/2", cnt_of(0), cnt_of(1)); end
    @(negedge clk);
    #1;
    vec_cnt++; if ({done, ch_ack} !== 5'b1_0000) begin err_cnt++; $display("FAIL dr_done_hold: got %b exp 10000", {done, ch_ack}); end
  endtask

  // Restart from DONE, steer rr_ptr to 2, then lanes 1 and 3 compete.
  task automatic test_rotate();
    @(negedge clk);
    ch_req = 4'b0;
    ch_last = 4'b0;
    cfg_start = 1'b1;
    cfg_base_addr = {16'h3000, 16'h2000, 16'h1000, 16'hFFFE};
    @(negedge clk);
    cfg_start = 1'b0;
    ch_req = 4'b0010;
    #1;
    vec_cnt++; if ({busy, done} !== 2'b10) begin err_cnt++; $display("FAIL rot_restart: got %b exp 10", {busy, done}); end
    vec_cnt++; if (ch_word_cnt !== '0) begin err_cnt++; $display("FAIL rot_cnt_clear: got %h exp 0", ch_word_cnt); end
    vec_cnt++; if (ch_ack !== 4'b0010) begin err_cnt++; $display("FAIL rot_ack_l1: got %b exp 0010", ch_ack); end
    @(negedge clk);
    ch_req = 4'b1010;
    #1;
    vec_cnt++; if (ch_ack !== 4'b1000) begin err_cnt++; $display("FAIL rot_ack_l3: got %b exp 1000", ch_ack); end
    vec_cnt++; if (wr_addr !== 16'h1000) begin err_cnt++; $display("FAIL rot_addr0: got %h exp 1000", wr_addr); end
    @(negedge clk);
    #1;
    vec_cnt++; if (ch_ack !== 4'b0010) begin err_cnt++; $display("FAIL rot_ack_l1b: got %b exp 0010", ch_ack); end
    vec_cnt++; if (wr_addr !== 16'h3000) begin err_cnt++; $display("FAIL rot_addr1: got %h exp 3000", wr_addr); end
    @(negedge clk);
    ch_req = 4'b0;
    #1;
    vec_cnt++; if (wr_addr !== 16'h1001) begin err_cnt++; $display("FAIL rot_addr2: got %h exp 1001", wr_addr); end
    vec_cnt++; if (cnt_of(3) !== 16'd1 || cnt_of(1) !== 16'd2) begin err_cnt++; $display("FAIL rot_cnt: got %0d/%0d exp 1/2", cnt_of(3), cnt_of(1)); end
  endtask

  // Lane 0 base 0xFFFE: address wraps modulo 2^16.
  task automatic test_addr_wrap();
    logic [ADDR_W-1:0] ea [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ch_req = (i < 3) ? 4'b0001 : 4'b0000;
      #1;
      if (i < 3) begin
        vec_cnt++; if (ch_ack !== 4'b0001) begin err_cnt++; $display("FAIL wr_ack[%0d]: got %b exp 0001", i, ch_ack); end
      end
      if (i > 0) begin
        vec_cnt++; if (wr_addr !== ea[i-1]) begin err_cnt++; $display("FAIL wrap_addr[%0d]: got %h exp %h", i, wr_addr, ea[i-1]); end
      end
    end
    @(negedge clk);
    #1;
    vec_cnt++; if (cnt_of(0) !== 16'd3) begin err_cnt++; $display("FAIL wrap_cnt0: got %0d exp 3", cnt_of(0)); end
    vec_cnt++; if (wr_en !== 1'b0) begin err_cnt++; $display("FAIL wrap_idle: got %b exp 0", wr_en); end
  endtask

  // Reset mid-burst clears everything at once; requests before cfg_start are ignored.
  task automatic test_reset_mid();
    @(negedge clk);
    ch_req = 4'hF;
    #1;
    vec_cnt++; if (ch_ack !== 4'b0010) begin err_cnt++; $display("FAIL rm_ack: got %b exp 0010", ch_ack); end
    @(negedge clk);
    #1;
    vec_cnt++; if (wr_en !== 1'b1) begin err_cnt++; $display("FAIL rm_burst: got %b exp 1", wr_en); end
    #1;
    rst = 1'b1;
    #1;
    vec_cnt++; if ({wr_en, wr_addr, wr_data} !== '0) begin err_cnt++; $display("FAIL rm_wr_clear: got %b/%h/%h exp 0", wr_en, wr_addr, wr_data); end
    vec_cnt++; if ({busy, done, ch_ack} !== 6'b0) begin err_cnt++; $display("FAIL rm_ctrl_clear: got %b exp 000000", {busy, done, ch_ack}); end
    vec_cnt++; if (ch_word_cnt !== '0) begin err_cnt++; $display("FAIL rm_cnt_clear: got %h exp 0", ch_word_cnt); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      vec_cnt++; if ({busy, ch_ack} !== 5'b0) begin err_cnt++; $display("FAIL rm_idle_ack[%0d]: got %b exp 00000", k, {busy, ch_ack}); end
      @(negedge clk);
    end
    cfg_start = 1'b1;
    cfg_base_addr = '0;
    #1;
    vec_cnt++; if (ch_ack !== 4'b0) begin err_cnt++; $display("FAIL rm_cfg_ack: got %b exp 0000", ch_ack); end
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
    vec_cnt++; if ({busy, ch_ack} !== 5'b1_0001) begin err_cnt++; $display("FAIL rm_first_grant: got %b exp 10001", {busy, ch_ack}); end
    @(negedge clk);
    ch_req = 4'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_drain_done();
    test_rotate();
    test_addr_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
